cu_vertex_cache_arbiter_control: RTL

- Shares one vertex cache read port between NUM_REQ edge-compute requesters using round-robin arbitration.
- Tracks outstanding lookups in an in-order requester-ID FIFO and steers each cache response back to the requester that issued it.
- Sequences cache flush/invalidate between PageRank iterations: stops new grants, drains in-flight lookups, then invalidates.
- Sits between the PULL-mode edge CUs and the vertex cache.

---
 rtl/cu_pkg.sv | 13 +
 rtl/cu_fifo.sv | 40 ++++
 rtl/cu_vertex_cache_rr_arbiter.sv | 36 +++
 rtl/cu_vertex_cache_arbiter_control.sv | 129 ++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// cu_pkg: shared types and constants for the compute-unit vertex cache path.
//   cache_arb_state_t : flush sequencer states of the vertex cache arbiter
//   vertex_rsp_t      : registered response line {hit, data}
package cu_pkg;
    localparam int NUM_VERTEX_CACHE_REQ         = 4;
    localparam int VERTEX_CACHE_MAX_OUTSTANDING = 8;
    localparam int VERTEX_DATA_W                = 64;
    typedef enum logic [2:0] {IDLE, ACTIVE, DRAIN, INVAL, DONE} cache_arb_state_t;
    typedef struct packed {
        logic                     hit;
        logic [VERTEX_DATA_W-1:0] data;
    } vertex_rsp_t;
endpackage

// File: rtl/cu_fifo.sv
// cu_fifo: synchronous FIFO primitive with occupancy count.
//   clock, rst_in (async, active-high)
//   push/push_data, pop/pop_data (first-word fall-through), count, empty
//   The caller never pushes when full unless popping in the same cycle,
//   and never pops when empty. DEPTH must be a power of two.
module cu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             rst_in,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    assign pop_data = mem[rd_ptr];
    assign empty    = count == '0;
    always_ff @(posedge clock or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/cu_vertex_cache_rr_arbiter.sv
// cu_vertex_cache_rr_arbiter: combinational round-robin grant with registered pointer.
//   clock, rst_in (async, active-high), enable gates all grants
//   req_valid -> grant (one-hot), grant_id, transfer (a grant was issued)
module cu_vertex_cache_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               rst_in,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               transfer
);
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] idx;
    // Scanning from the far end means the candidate nearest the pointer wins.
    always_comb begin
        grant_id = ptr;
        transfer = 1'b0;
        idx      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (enable && req_valid[idx]) begin
                grant_id = idx;
                transfer = 1'b1;
            end
        end
    end
    assign grant = transfer ? NUM_REQ'(1) << grant_id : '0;
    always_ff @(posedge clock or posedge rst_in) begin
        if (rst_in) ptr <= '0;
        else if (transfer) ptr <= ID_W'((int'(grant_id) + 1) % NUM_REQ);
    end
endmodule

// File: rtl/cu_vertex_cache_arbiter_control.sv
// cu_vertex_cache_arbiter_control: round-robin share of the vertex cache read port with in-order response steering and flush sequencing.
//   clock, rst_in (async, active-high), enabled_in
//   req_valid_in/req_cmd_in/req_ready_out        : requester command side
//   cache_cmd_valid_out/cache_cmd_out             : lookup to cache (1-cycle latency)
//   cache_rsp_valid_in/_hit_in/_data_in           : in-order cache responses
//   rsp_valid_out/rsp_hit_out/rsp_data_out        : steered responses (1-cycle latency)
//   flush_req_in, cache_invalidate_out, flush_done_out, error_out (sticky)
//   Optional macro CU_VERTEX_CACHE_ARB_STATS_EN adds saturating hit/miss/grant counters.
module cu_vertex_cache_arbiter_control
    import cu_pkg::*;
#(
    parameter int NUM_REQ         = NUM_VERTEX_CACHE_REQ,
    parameter int CMD_W           = 64,
    parameter int DATA_W          = VERTEX_DATA_W,
    parameter int MAX_OUTSTANDING = VERTEX_CACHE_MAX_OUTSTANDING,
    parameter int REQ_ID_W        = $clog2(NUM_REQ)
) (
    input  logic                     clock,
    input  logic                     rst_in,
    input  logic                     enabled_in,
    input  logic [NUM_REQ-1:0]       req_valid_in,
    input  logic [NUM_REQ*CMD_W-1:0] req_cmd_in,
    output logic [NUM_REQ-1:0]       req_ready_out,
    output logic                     cache_cmd_valid_out,
    output logic [CMD_W-1:0]         cache_cmd_out,
    input  logic                     cache_rsp_valid_in,
    input  logic                     cache_rsp_hit_in,
    input  logic [DATA_W-1:0]        cache_rsp_data_in,
    output logic [NUM_REQ-1:0]       rsp_valid_out,
    output logic                     rsp_hit_out,
    output logic [DATA_W-1:0]        rsp_data_out,
    input  logic                     flush_req_in,
    output logic                     cache_invalidate_out,
    output logic                     flush_done_out,
    output logic                     error_out
`ifdef CU_VERTEX_CACHE_ARB_STATS_EN
    ,
    output logic [31:0]              hit_count_out,
    output logic [31:0]              miss_count_out,
    output logic [31:0]              grant_count_out
`endif
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    cache_arb_state_t    state;
    logic [CNT_W-1:0]    outstanding;
    logic                fifo_empty;
    logic                pop;
    logic                grant_en;
    logic                transfer;
    logic [REQ_ID_W-1:0] grant_id;
    logic [REQ_ID_W-1:0] head_id;
    vertex_rsp_t         rsp_q;
    assign pop          = cache_rsp_valid_in && !fifo_empty;
    // A same-cycle pop frees a slot, so a full FIFO may still accept a grant.
    assign grant_en     = state == ACTIVE && (outstanding < CNT_W'(MAX_OUTSTANDING) || pop);
    assign rsp_hit_out  = rsp_q.hit;
    assign rsp_data_out = DATA_W'(rsp_q.data);
    cu_vertex_cache_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(REQ_ID_W)) u_arb (
        .clock     (clock),
        .rst_in    (rst_in),
        .enable    (grant_en),
        .req_valid (req_valid_in),
        .grant     (req_ready_out),
        .grant_id  (grant_id),
        .transfer  (transfer)
    );
    cu_fifo #(.WIDTH(REQ_ID_W), .DEPTH(MAX_OUTSTANDING), .CNT_W(CNT_W)) u_id_fifo (
        .clock     (clock),
        .rst_in    (rst_in),
        .push      (transfer),
        .push_data (grant_id),
        .pop       (pop),
        .pop_data  (head_id),
        .count     (outstanding),
        .empty     (fifo_empty)
    );
    always_ff @(posedge clock or posedge rst_in) begin
        if (rst_in) begin
            cache_cmd_valid_out <= 1'b0;
            cache_cmd_out       <= '0;
            rsp_valid_out       <= '0;
            rsp_q               <= '0;
            error_out           <= 1'b0;
        end else begin
            cache_cmd_valid_out <= transfer;
            if (transfer) cache_cmd_out <= req_cmd_in[grant_id*CMD_W +: CMD_W];
            rsp_valid_out <= pop ? NUM_REQ'(1) << head_id : '0;
            if (pop) rsp_q <= '{hit: cache_rsp_hit_in, data: VERTEX_DATA_W'(cache_rsp_data_in)};
            if (cache_rsp_valid_in && fifo_empty) error_out <= 1'b1;
        end
    end
    // Invalidate waits until both the FIFO and the response register are empty.
    always_ff @(posedge clock or posedge rst_in) begin
        if (rst_in) begin
            state                <= IDLE;
            cache_invalidate_out <= 1'b0;
            flush_done_out       <= 1'b0;
        end else begin
            cache_invalidate_out <= 1'b0;
            flush_done_out       <= 1'b0;
            case (state)
                IDLE:    if (enabled_in) state <= ACTIVE;
                ACTIVE:  state <= flush_req_in ? DRAIN : enabled_in ? ACTIVE : IDLE;
                DRAIN:   if (outstanding == '0 && rsp_valid_out == '0) begin
                    state                <= INVAL;
                    cache_invalidate_out <= 1'b1;
                end
                INVAL: begin
                    state          <= DONE;
                    flush_done_out <= 1'b1;
                end
                default: state <= enabled_in ? ACTIVE : IDLE;
            endcase
        end
    end
`ifdef CU_VERTEX_CACHE_ARB_STATS_EN
    always_ff @(posedge clock or posedge rst_in) begin
        if (rst_in || state == INVAL) begin
            hit_count_out   <= '0;
            miss_count_out  <= '0;
            grant_count_out <= '0;
        end else begin
            if (pop && cache_rsp_hit_in && hit_count_out != '1) hit_count_out <= hit_count_out + 32'd1;
            if (pop && !cache_rsp_hit_in && miss_count_out != '1) miss_count_out <= miss_count_out + 32'd1;
            if (transfer && grant_count_out != '1) grant_count_out <= grant_count_out + 32'd1;
        end
    end
`endif
endmodule
